// File: rtl/clk_freq_meter_if.sv
// Start/test-clock inputs and measurement results of clk_freq_meter.
// high_count exists only when CLK_FREQ_METER_DUTY_EN is defined.
interface clk_freq_meter_if #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W = 16
);
  typedef logic [$clog2(GATE_CYCLES + 1)-1:0] high_count_t;

  logic             start;
  logic             clk_test;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

`ifdef CLK_FREQ_METER_DUTY_EN
  high_count_t high_count;

  modport master (output start, clk_test, input busy, done, count, overflow, high_count);
  modport slave  (input start, clk_test, output busy, done, count, overflow, high_count);
`else
  modport master (output start, clk_test, input busy, done, count, overflow);
  modport slave  (input start, clk_test, output busy, done, count, overflow);
`endif
endinterface

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous test clock over a GATE_CYCLES window of CLK_in.
// Define CLK_FREQ_METER_DUTY_EN to also report how many gate cycles saw the test clock high.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input logic             CLK_in,
  input logic             RST,
  clk_freq_meter_if.slave bus
);
  localparam int TMR_W = $clog2(GATE_CYCLES);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             rise;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;
  logic             ovf;
  logic             ovf_next;
  logic             at_max;

`ifdef CLK_FREQ_METER_DUTY_EN
  localparam int HC_W = $clog2(GATE_CYCLES + 1);
  logic [HC_W-1:0] hc_acc;
  logic [HC_W-1:0] hc_next;

  assign hc_next = hc_acc + HC_W'(sync2);
`endif

  // The test clock is only ever data here; it free-runs through the synchroniser in every state.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.clk_test;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise     = sync2 & ~prev;
  assign at_max   = &acc;
  assign acc_next = (rise && !at_max) ? acc + CNT_W'(1) : acc;
  assign ovf_next = ovf | (rise & at_max);

  // Results are loaded on the edge into DONE so count is already valid while done is high.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      timer        <= '0;
      acc          <= '0;
      ovf          <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
`ifdef CLK_FREQ_METER_DUTY_EN
      hc_acc         <= '0;
      bus.high_count <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            ovf      <= 1'b0;
            timer    <= TMR_W'(GATE_CYCLES - 1);
            bus.busy <= 1'b1;
            state    <= GATE;
`ifdef CLK_FREQ_METER_DUTY_EN
            hc_acc <= '0;
`endif
          end
        end
        GATE: begin
          acc <= acc_next;
          ovf <= ovf_next;
`ifdef CLK_FREQ_METER_DUTY_EN
          hc_acc <= hc_next;
`endif
          if (timer == '0) begin
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.count    <= acc_next;
            bus.overflow <= ovf_next;
`ifdef CLK_FREQ_METER_DUTY_EN
            bus.high_count <= hc_next;
`endif
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter: a 16-bit and a 4-bit counter instance share the
// same stimulus; expected counts come from the periods of the driven test waveforms.
module tb_clk_freq_meter;
  localparam int G    = 1000;
  localparam int HC_W = $clog2(G + 1);

  logic        CLK_in = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        src;
  int          sel = 0;
  int unsigned tick = 0;
  int unsigned rper = 2;
  int unsigned rhigh = 1;
  int unsigned rphase = 0;
  int          checks = 0;
  int          failures = 0;
  int          done16 = 0;

  always #5 CLK_in = ~CLK_in;

  clk_freq_meter_if #(.GATE_CYCLES(G), .CNT_W(16)) bus16 ();
  clk_freq_meter_if #(.GATE_CYCLES(G), .CNT_W(4))  bus4 ();

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) u16 (.CLK_in(CLK_in), .RST(RST), .bus(bus16));
  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4))  u4  (.CLK_in(CLK_in), .RST(RST), .bus(bus4));

  assign bus16.start    = start;
  assign bus16.clk_test = src;
  assign bus4.start     = start;
  assign bus4.clk_test  = src;

  // Divided clocks all derive from one negedge counter, so CLK_50/CLK_10/CLK_1 stay phase-locked
  always @(negedge CLK_in) tick <= tick + 1;

  always_comb begin
    src = 1'b0;
    case (sel)
      1:       src = 1'b1;
      2:       src = ((tick % 2) == 0);
      3:       src = ((tick % 10) < 5);
      4:       src = ((tick % 100) < 50);
      5:       src = (((tick + rphase) % rper) < rhigh);
      default: src = 1'b0;
    endcase
  end

  always @(posedge CLK_in) if (bus16.done === 1'b1) done16 <= done16 + 1;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit reached, required run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Periodic waveform of period p whose period divides G: exactly G/p rising edges per window
  function automatic int exp_rises(int p);
    return (p == 0) ? 0 : G / p;
  endfunction

  function automatic int sat4(int r);
    return (r > 15) ? 15 : r;
  endfunction

  task automatic run_measure(output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    start = 1'b1;
    while (lat < 3000 && !ok) begin
      @(negedge CLK_in);
      lat++;
      start = 1'b0;
      if (bus16.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    sel = 0;
    repeat (3) @(negedge CLK_in);
    checks++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.count !== 16'd0 || bus16.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_w16: busy=%b done=%b count=%0d ovf=%b, required all 0",
               bus16.busy, bus16.done, bus16.count, bus16.overflow);
    end
    checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.count !== 4'd0 || bus4.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_w4: busy=%b done=%b count=%0d ovf=%b, required all 0",
               bus4.busy, bus4.done, bus4.count, bus4.overflow);
    end
`ifdef CLK_FREQ_METER_DUTY_EN
    checks++;
    if (bus16.high_count !== HC_W'(0)) begin
      failures++;
      $display("[TB] FAIL reset_high_count: got %0d, required 0", bus16.high_count);
    end
`endif
    RST = 1'b0;
    repeat (5) @(negedge CLK_in);
    checks++;
    if (bus16.busy !== 1'b0 || done16 != 0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy=%b done_pulses=%0d, required 0 and 0", bus16.busy, done16);
    end
  endtask

  task automatic test_clk50();
    int lat;
    bit ok;
    int r;
    sel = 2;
    repeat ($urandom_range(5, 20)) @(negedge CLK_in);
    r = exp_rises(2);
    run_measure(lat, ok);
    checks++;
    if (!ok || lat != G + 1 || bus4.done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clk50_latency: done seen=%0d after %0d cycles (w4 done=%b), required %0d", ok, lat, bus4.done, G + 1);
    end
    checks++;
    if (bus16.count !== 16'(r) || bus16.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clk50_w16: count=%0d ovf=%b, required %0d ovf=0", bus16.count, bus16.overflow, r);
    end
    checks++;
    if (bus4.count !== 4'(sat4(r)) || bus4.overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clk50_w4_sat: count=%0d ovf=%b, required %0d ovf=1", bus4.count, bus4.overflow, sat4(r));
    end
`ifdef CLK_FREQ_METER_DUTY_EN
    checks++;
    if (bus16.high_count !== HC_W'(G / 2)) begin
      failures++;
      $display("[TB] FAIL clk50_high_count: got %0d, required %0d", bus16.high_count, G / 2);
    end
`endif
    @(negedge CLK_in);
    checks++;
    if (bus16.done !== 1'b0 || bus16.busy !== 1'b0 || bus16.count !== 16'(r)) begin
      failures++;
      $display("[TB] FAIL clk50_after_done: done=%b busy=%b count=%0d, required 0 0 %0d", bus16.done, bus16.busy, bus16.count, r);
    end
  endtask

  task automatic test_stuck();
    int lat;
    bit ok;
    int d0;
    for (int lvl = 0; lvl < 2; lvl++) begin
      sel = lvl;
      repeat (10) @(negedge CLK_in);
      d0 = done16;
      run_measure(lat, ok);
      repeat (3) @(negedge CLK_in);
      checks++;
      if (!ok || done16 - d0 != 1) begin
        failures++;
        $display("[TB] FAIL stuck%0d_done_pulses: got %0d pulses, required 1", lvl, done16 - d0);
      end
      checks++;
      if (bus16.count !== 16'd0 || bus16.overflow !== 1'b0 || bus4.count !== 4'd0 || bus4.overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stuck%0d_count: w16=%0d/%b w4=%0d/%b, required 0/0", lvl,
                 bus16.count, bus16.overflow, bus4.count, bus4.overflow);
      end
`ifdef CLK_FREQ_METER_DUTY_EN
      checks++;
      if (bus16.high_count !== HC_W'(lvl * G)) begin
        failures++;
        $display("[TB] FAIL stuck%0d_high_count: got %0d, required %0d", lvl, bus16.high_count, lvl * G);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int k;
    int lat2;
    bit ok;
    logic b_gap;
    logic b_next;
    sel = 3;
    // Window edges land where CLK_10 and CLK_1 are both low, so the source swap adds no edge
    n = 0;
    do begin
      @(negedge CLK_in);
      n++;
    end while (tick % 100 != 58 && n < 300);
    start = 1'b1;
    k = 0;
    ok = 1'b0;
    while (k < 3000 && !ok) begin
      @(negedge CLK_in);
      k++;
      if (k > 900 && sel == 3 && (tick % 100) == 54) sel = 4;
      if (bus16.done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || k != G + 1) begin
      failures++;
      $display("[TB] FAIL b2b_run1_latency: %0d cycles (seen=%0d), required %0d", k, ok, G + 1);
    end
    checks++;
    if (bus16.count !== 16'(exp_rises(10)) || bus16.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_clk10_w16: count=%0d ovf=%b, required %0d ovf=0", bus16.count, bus16.overflow, exp_rises(10));
    end
    checks++;
    if (bus4.count !== 4'(sat4(exp_rises(10))) || bus4.overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_clk10_w4: count=%0d ovf=%b, required %0d ovf=1", bus4.count, bus4.overflow, sat4(exp_rises(10)));
    end
    @(negedge CLK_in);
    b_gap = bus16.busy;
    @(negedge CLK_in);
    b_next = bus16.busy;
    start = 1'b0;
    checks++;
    if (b_gap !== 1'b0 || b_next !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_busy_gap: busy after done=%b then %b, required 0 then 1", b_gap, b_next);
    end
    lat2 = 0;
    ok = 1'b0;
    while (lat2 < 3000 && !ok) begin
      @(negedge CLK_in);
      lat2++;
      if (bus16.done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || lat2 != G) begin
      failures++;
      $display("[TB] FAIL b2b_run2_latency: %0d cycles after busy rose (seen=%0d), required %0d", lat2, ok, G);
    end
    checks++;
    if (bus16.count !== 16'(exp_rises(100)) || bus16.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_clk1_w16: count=%0d ovf=%b, required %0d ovf=0", bus16.count, bus16.overflow, exp_rises(100));
    end
    checks++;
    if (bus4.count !== 4'(sat4(exp_rises(100))) || bus4.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_clk1_w4_ovf_clear: count=%0d ovf=%b, required %0d ovf=0", bus4.count, bus4.overflow, sat4(exp_rises(100)));
    end
`ifdef CLK_FREQ_METER_DUTY_EN
    checks++;
    if (bus16.high_count !== HC_W'(G / 2)) begin
      failures++;
      $display("[TB] FAIL b2b_clk1_high_count: got %0d, required %0d", bus16.high_count, G / 2);
    end
`endif
    repeat (3) @(negedge CLK_in);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    int d0;
    sel = 3;
    repeat (10) @(negedge CLK_in);
    start = 1'b1;
    @(negedge CLK_in);
    start = 1'b0;
    repeat (400) @(negedge CLK_in);
    RST = 1'b1;
    #1;
    checks++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.count !== 16'd0 || bus16.overflow !== 1'b0 ||
        bus4.busy !== 1'b0 || bus4.count !== 4'd0 || bus4.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_clear: w16 busy=%b done=%b count=%0d ovf=%b w4 busy=%b count=%0d ovf=%b, required all 0",
               bus16.busy, bus16.done, bus16.count, bus16.overflow, bus4.busy, bus4.count, bus4.overflow);
    end
    @(negedge CLK_in);
    RST = 1'b0;
    d0 = done16;
    repeat (1200) @(negedge CLK_in);
    checks++;
    if (done16 != d0 || bus16.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done: pulses=%0d busy=%b, required 0 pulses busy=0", done16 - d0, bus16.busy);
    end
    run_measure(lat, ok);
    checks++;
    if (!ok || lat != G + 1 || bus16.count !== 16'(exp_rises(10))) begin
      failures++;
      $display("[TB] FAIL reset_mid_rerun: latency=%0d count=%0d, required %0d and %0d", lat, bus16.count, G + 1, exp_rises(10));
    end
    repeat (3) @(negedge CLK_in);
  endtask

  task automatic test_start_ignored();
    int lat;
    bit ok;
    int d0;
    sel = 2;
    repeat (10) @(negedge CLK_in);
    d0 = done16;
    start = 1'b1;
    lat = 0;
    ok = 1'b0;
    while (lat < 3000 && !ok) begin
      @(negedge CLK_in);
      lat++;
      start = (lat == 300);
      if (bus16.done === 1'b1) ok = 1'b1;
    end
    start = 1'b1;
    @(negedge CLK_in);
    start = 1'b0;
    repeat (1200) @(negedge CLK_in);
    checks++;
    if (!ok || lat != G + 1) begin
      failures++;
      $display("[TB] FAIL ignore_gate_start: latency=%0d (seen=%0d), required %0d", lat, ok, G + 1);
    end
    checks++;
    if (done16 - d0 != 1 || bus16.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_done_start: pulses=%0d busy=%b, required 1 pulse busy=0", done16 - d0, bus16.busy);
    end
    checks++;
    if (bus16.count !== 16'(exp_rises(2)) || bus4.count !== 4'(sat4(exp_rises(2))) || bus4.overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ignore_result: w16=%0d w4=%0d ovf4=%b, required %0d %0d 1",
               bus16.count, bus4.count, bus4.overflow, exp_rises(2), sat4(exp_rises(2)));
    end
  endtask

  task automatic test_random();
    int periods[13] = '{2, 4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250};
    int lat;
    bit ok;
    int p;
    int r;
    for (int it = 0; it < 5; it++) begin
      p      = periods[$urandom_range(0, 12)];
      rper   = p;
      rhigh  = $urandom_range(1, p - 1);
      rphase = $urandom_range(0, 999);
      sel    = 5;
      r      = exp_rises(p);
      repeat ($urandom_range(5, 50)) @(negedge CLK_in);
      run_measure(lat, ok);
      checks++;
      if (!ok || lat != G + 1 || bus16.count !== 16'(r) || bus16.overflow !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random_w16 P=%0d: latency=%0d count=%0d ovf=%b, required %0d %0d 0",
                 p, lat, bus16.count, bus16.overflow, G + 1, r);
      end
      checks++;
      if (bus4.count !== 4'(sat4(r)) || bus4.overflow !== (r > 15)) begin
        failures++;
        $display("[TB] FAIL random_w4 P=%0d: count=%0d ovf=%b, required %0d %0d", p, bus4.count, bus4.overflow, sat4(r), r > 15);
      end
`ifdef CLK_FREQ_METER_DUTY_EN
      checks++;
      if (bus16.high_count !== HC_W'(G / p * int'(rhigh))) begin
        failures++;
        $display("[TB] FAIL random_high_count P=%0d H=%0d: got %0d, required %0d", p, rhigh, bus16.high_count, G / p * int'(rhigh));
      end
`endif
      repeat (2) @(negedge CLK_in);
    end
  endtask

  initial begin
    test_reset();
    test_clk50();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
